// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick_timer block: state encoding and default counter width.
package tick_timer_pkg;

  localparam int unsigned DefaultWidth = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StFire = ST_FIRE
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a slow square wave already synchronous to clk_in.
module rise_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/tick_timer.sv
// One-shot countdown timer decremented on each rising edge of tick_in; pulses irq on expiry.
// Define TICK_TIMER_AUTORELOAD_EN to make expiry reload the count for periodic interrupts.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             load_we,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic             irq,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] eff_reload;
  logic             tick_rise;

  rise_detect u_rise_detect (
    .clk_in (clk_in),
    .reset  (reset),
    .sig_i  (tick_in),
    .rise_o (tick_rise)
  );

  // A same-cycle write is visible to start immediately.
  assign eff_reload = load_we ? load_val : reload_q;
  assign reload_d   = load_we ? load_val : reload_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (tick_rise && (count_q != '0)) begin
          count_d = count_q - WIDTH'(1);
          if (count_q == WIDTH'(1)) begin
            state_d = StFire;
          end
        end
      end
      StFire: begin
`ifdef TICK_TIMER_AUTORELOAD_EN
        if (reload_q != '0) begin
          count_d = reload_q;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    // start overrides everything, including stop and a pending expiry.
    if (start) begin
      if (eff_reload != '0) begin
        count_d = eff_reload;
        state_d = StRun;
      end else begin
        state_d = StFire;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign irq   = (state_q == StFire);
  assign busy  = (state_q == StRun);
  assign count = count_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_tick_timer;

  localparam int unsigned W = 16;

  logic         clk_in = 1'b0;
  logic         reset = 1'b1;
  logic         tick_in = 1'b0;
  logic         load_we = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         irq;
  logic         busy;
  logic [W-1:0] count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int irq_cnt = 0;

  // Behavioural model: running flag, pending-expiry flag, remaining ticks, stored reload.
  bit m_valid = 1'b0;
  bit m_run = 1'b0;
  bit m_fire = 1'b0;
  int m_count = 0;
  int m_reload = 0;
  bit m_prev_tick = 1'b0;

  tick_timer #(.WIDTH(W)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .tick_in  (tick_in),
    .load_we  (load_we),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .irq      (irq),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk_in) begin
    bit rise;
    bit nrun, nfire;
    int cnt, eff;
    rise = tick_in && !m_prev_tick;
    m_prev_tick = reset ? 1'b0 : tick_in;
    if (reset) begin
      m_run = 0; m_fire = 0; m_count = 0; m_reload = 0;
      m_valid = 1'b1;
    end else begin
      eff   = load_we ? int'(load_val) : m_reload;
      nrun  = m_run;
      nfire = 1'b0;
      cnt   = m_count;
      if (m_run) begin
        if (stop) nrun = 1'b0;
        else if (rise && cnt > 0) begin
          cnt = cnt - 1;
          if (cnt == 0) begin nrun = 1'b0; nfire = 1'b1; end
        end
      end
`ifdef TICK_TIMER_AUTORELOAD_EN
      if (m_fire && m_reload != 0) begin cnt = m_reload; nrun = 1'b1; end
`endif
      if (start) begin
        if (eff != 0) begin cnt = eff; nrun = 1'b1; nfire = 1'b0; end
        else begin nfire = 1'b1; nrun = 1'b0; end
      end
      if (load_we) m_reload = int'(load_val);
      m_run = nrun; m_fire = nfire; m_count = cnt;
    end
  end

  always @(negedge clk_in) begin
    if (m_valid) begin
      check("model_irq", int'(irq), int'(m_fire));
      check("model_busy", int'(busy), int'(m_run));
      check("model_count", int'(count), m_count);
    end
    if (irq) irq_cnt++;
  end

  task automatic tick_clk();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_out(input string name, input int e_cnt, input int e_busy, input int e_irq);
    check({name, "_count"}, int'(count), e_cnt);
    check({name, "_busy"}, int'(busy), e_busy);
    check({name, "_irq"}, int'(irq), e_irq);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; stop = 0; load_we = 0;
    tick_clk(); tick_clk();
    reset = 1'b0;
  endtask

  // One full tick_in period: rising edge then falling edge.
  task automatic edge_pair();
    tick_in = 1'b1; tick_clk();
    tick_in = 1'b0; tick_clk();
  endtask

  initial begin
    int base;
    // Reset state and basic 3-tick countdown.
    tick_clk();
    do_reset();
    expect_out("reset", 0, 0, 0);
    load_we = 1; load_val = 3; tick_clk();
    load_we = 0; start = 1; tick_clk();
    start = 0;
    expect_out("start3", 3, 1, 0);
    tick_in = 1; tick_clk(); expect_out("edge1", 2, 1, 0);
    tick_in = 0; tick_clk();
    tick_in = 1; tick_clk(); expect_out("edge2", 1, 1, 0);
    tick_in = 0; tick_clk();
    tick_in = 1; tick_clk(); expect_out("edge3", 0, 0, 1);
    tick_in = 0; tick_clk(); expect_out("after_fire", 0, 0, 0);

    // Load and start in the same cycle.
    load_we = 1; load_val = 5; start = 1; tick_clk();
    load_we = 0; start = 0;
    expect_out("load_start", 5, 1, 0);
    stop = 1; tick_clk(); stop = 0;
    expect_out("stop_idle", 5, 0, 0);

    // Zero reload fires immediately without busy.
    load_we = 1; load_val = 0; start = 1; tick_clk();
    load_we = 0; start = 0;
    expect_out("zero_fire", 5, 0, 1);
    tick_clk(); expect_out("zero_after", 5, 0, 0);

    // stop wins over a simultaneous tick edge.
    load_we = 1; load_val = 2; start = 1; tick_clk();
    load_we = 0; start = 0;
    tick_in = 1; stop = 1; tick_clk();
    stop = 0;
    expect_out("stop_vs_tick", 2, 0, 0);
    base = irq_cnt;
    tick_in = 0; tick_clk();
    edge_pair(); edge_pair(); edge_pair();
    check("stop_no_irq", irq_cnt - base, 0);

    // tick_in high across reset release is not a tick.
    tick_in = 1; do_reset();
    tick_clk();
    load_we = 1; load_val = 2; start = 1; tick_clk();
    load_we = 0; start = 0;
    tick_clk(); tick_clk();
    expect_out("held_high", 2, 1, 0);
    tick_in = 0; tick_clk();
    tick_in = 1; tick_clk();
    expect_out("first_real_edge", 1, 1, 0);
    tick_in = 0; stop = 1; tick_clk(); stop = 0;

    // Six edges at reload=2, stop after the fifth.
    do_reset();
    base = irq_cnt;
    load_we = 1; load_val = 2; start = 1; tick_clk();
    load_we = 0; start = 0;
    for (int i = 0; i < 5; i++) edge_pair();
    stop = 1; tick_clk(); stop = 0;
    edge_pair(); tick_clk();
`ifdef TICK_TIMER_AUTORELOAD_EN
    check("periodic_irqs", irq_cnt - base, 2);
`else
    check("oneshot_irqs", irq_cnt - base, 1);
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 29) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      load_we  = ($urandom_range(0, 9) == 0);
      load_val = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
      tick_clk();
    end
    reset = 0; start = 0; stop = 0; load_we = 0;
    tick_clk(); tick_clk();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
